// File: rtl/uart_apb_slave_pkg.sv
// Shared definitions for the UART APB slave: register offsets, bit positions, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_apb_pkg;

    // Word offsets, as decoded from paddr[3:2]
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_DIV  = 2'd2;
    localparam logic [1:0] ADDR_IE   = 2'd3;

    // STATUS register bit positions
    localparam int STAT_RX_EMPTY = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_OVF   = 2;
    localparam int STAT_RX_UDF   = 3;

    // IE register bit positions
    localparam int IE_RX  = 0;
    localparam int IE_TX  = 1;
    localparam int IE_ERR = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAP  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/uart_apb_slave_if.sv
// APB3 bus bundle between a master and the UART register slave.
// Latency: n/a (wiring only).
// Backpressure: slave stretches transfers by holding pready low.
// Ports: psel/penable/pwrite/paddr/pwdata from master; prdata/pready/pslverr from slave.
interface uart_apb_slave_if #(
    parameter int DBIT = 8
);
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [3:0]      paddr;
    logic [DBIT-1:0] pwdata;
    logic [DBIT-1:0] prdata;
    logic            pready;
    logic            pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/uart_apb_slave.sv
// APB3 register slave fronting the UART: TX push / RX pop strobes, baud divisor, sticky errors, irq.
// Latency: pready 1 cycle after the access phase; 3 cycles for a DATA read that pops the RX FIFO.
// Backpressure: one transfer in flight; new accesses are only accepted in IDLE.
// Ports: clk, reset_n (async low); apb (slave modport); w_data/wr_uart and rd_uart/r_data to the
//        uart FIFOs; rx_empty/tx_full FIFO status; uart_paddr, timer_final_value, irq outputs.
module uart_apb_slave
    import uart_apb_pkg::*;
#(
    parameter int              DBIT        = 8,
    parameter logic [DBIT-1:0] DEFAULT_DIV = DBIT'(162)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_apb_slave_if.slave      apb,
    output logic [DBIT-1:0]      w_data,
    output logic                 wr_uart,
    output logic                 rd_uart,
    input  logic [DBIT-1:0]      r_data,
    input  logic                 rx_empty,
    input  logic                 tx_full,
    output logic [1:0]           uart_paddr,
    output logic [DBIT-1:0]      timer_final_value,
    output logic                 irq
);

    state_t          state_q, state_d;
    logic [DBIT-1:0] prdata_q, prdata_d;
    logic            pready_q, pready_d;
    logic            pslverr_q, pslverr_d;
    logic [DBIT-1:0] w_data_q, w_data_d;
    logic            wr_uart_q, wr_uart_d;
    logic            rd_uart_q, rd_uart_d;
    logic [1:0]      uart_paddr_q, uart_paddr_d;
    logic [DBIT-1:0] div_q, div_d;
    logic [2:0]      ie_q, ie_d;
    logic            tx_ovf_q, tx_ovf_d;
    logic            rx_udf_q, rx_udf_d;
    logic            irq_q, irq_d;

    logic            tx_ovf_set, rx_udf_set;
    logic            tx_ovf_clr, rx_udf_clr;
    logic [DBIT-1:0] status_val;
    logic [DBIT-1:0] ie_val;
    logic [1:0]      unused_paddr_lo;

    // Byte-lane bits of the address are ignored
    assign unused_paddr_lo = apb.paddr[1:0];

    always_comb begin
        status_val                = '0;
        status_val[STAT_RX_EMPTY] = rx_empty;
        status_val[STAT_TX_FULL]  = tx_full;
        status_val[STAT_TX_OVF]   = tx_ovf_q;
        status_val[STAT_RX_UDF]   = rx_udf_q;
        ie_val                    = '0;
        ie_val[2:0]               = ie_q;
    end

    always_comb begin
        state_d      = state_q;
        prdata_d     = prdata_q;
        pready_d     = 1'b0;
        pslverr_d    = 1'b0;
        w_data_d     = w_data_q;
        wr_uart_d    = 1'b0;
        rd_uart_d    = 1'b0;
        uart_paddr_d = uart_paddr_q;
        div_d        = div_q;
        ie_d         = ie_q;
        tx_ovf_set   = 1'b0;
        rx_udf_set   = 1'b0;
        tx_ovf_clr   = 1'b0;
        rx_udf_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (apb.psel && apb.penable) begin
                    uart_paddr_d = apb.paddr[3:2];
                    // Default: plain access answered in the next cycle
                    state_d      = RESP;
                    pready_d     = 1'b1;
                    case (apb.paddr[3:2])
                        ADDR_DATA: begin
                            if (apb.pwrite) begin
                                if (tx_full) begin
                                    tx_ovf_set = 1'b1;
                                    pslverr_d  = 1'b1;
                                end else begin
                                    wr_uart_d = 1'b1;
                                    w_data_d  = apb.pwdata;
                                end
                            end else if (rx_empty) begin
                                prdata_d   = '0;
                                rx_udf_set = 1'b1;
                                pslverr_d  = 1'b1;
                            end else begin
                                // Pop now, capture r_data a cycle later, answer after that
                                rd_uart_d = 1'b1;
                                pready_d  = 1'b0;
                                state_d   = POP;
                            end
                        end
                        ADDR_STAT: begin
                            if (apb.pwrite) begin
                                tx_ovf_clr = apb.pwdata[STAT_TX_OVF];
                                rx_udf_clr = apb.pwdata[STAT_RX_UDF];
                            end else begin
                                prdata_d = status_val;
                            end
                        end
                        ADDR_DIV: begin
                            if (apb.pwrite) div_d    = apb.pwdata;
                            else            prdata_d = div_q;
                        end
                        ADDR_IE: begin
                            if (apb.pwrite) ie_d     = apb.pwdata[2:0];
                            else            prdata_d = ie_val;
                        end
                        default: ;
                    endcase
                end
            end
            POP: begin
                state_d = CAP;
            end
            CAP: begin
                prdata_d = r_data;
                pready_d = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Set wins over a simultaneous W1C clear
        tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~tx_ovf_clr);
        rx_udf_d = rx_udf_set | (rx_udf_q & ~rx_udf_clr);

        irq_d = (ie_q[IE_RX]  & ~rx_empty) |
                (ie_q[IE_TX]  & ~tx_full)  |
                (ie_q[IE_ERR] & (tx_ovf_q | rx_udf_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            prdata_q     <= '0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            w_data_q     <= '0;
            wr_uart_q    <= 1'b0;
            rd_uart_q    <= 1'b0;
            uart_paddr_q <= 2'b00;
            div_q        <= DEFAULT_DIV;
            ie_q         <= 3'b000;
            tx_ovf_q     <= 1'b0;
            rx_udf_q     <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prdata_q     <= prdata_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            w_data_q     <= w_data_d;
            wr_uart_q    <= wr_uart_d;
            rd_uart_q    <= rd_uart_d;
            uart_paddr_q <= uart_paddr_d;
            div_q        <= div_d;
            ie_q         <= ie_d;
            tx_ovf_q     <= tx_ovf_d;
            rx_udf_q     <= rx_udf_d;
            irq_q        <= irq_d;
        end
    end

    assign apb.prdata        = prdata_q;
    assign apb.pready        = pready_q;
    assign apb.pslverr       = pslverr_q;
    assign w_data            = w_data_q;
    assign wr_uart           = wr_uart_q;
    assign rd_uart           = rd_uart_q;
    assign uart_paddr        = uart_paddr_q;
    assign timer_final_value = div_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_uart_apb_slave.sv
// Scoreboard bench for uart_apb_slave: random APB traffic against a register-level reference model.
// Latency: expected pready cycle is carried in each scoreboard entry.
// Backpressure: bench waits (bounded) on pready before starting the next transfer.
module tb_uart_apb_slave;
    import uart_apb_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] w_data, r_data, timer_final_value;
    logic       wr_uart, rd_uart, rx_empty, tx_full, irq;
    logic [1:0] uart_paddr;

    always #5 clk = ~clk;

    uart_apb_slave_if #(.DBIT(8)) apb ();

    uart_apb_slave #(.DBIT(8), .DEFAULT_DIV(8'd162)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .apb               (apb),
        .w_data            (w_data),
        .wr_uart           (wr_uart),
        .rd_uart           (rd_uart),
        .r_data            (r_data),
        .rx_empty          (rx_empty),
        .tx_full           (tx_full),
        .uart_paddr        (uart_paddr),
        .timer_final_value (timer_final_value),
        .irq               (irq)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] prdata; logic err; int due; } resp_t;
    typedef struct { logic [7:0] dat; int due; } tx_t;
    resp_t rq[$];
    tx_t   txq[$];

    // Reference model state
    logic [7:0] m_div;
    logic [2:0] m_ie;
    logic       m_ovf, m_udf;
    logic [7:0] m_prdata;
    logic [7:0] rx_next;
    int         rd_exp = 0;
    int         rd_seen = 0;

    // UART RX FIFO stand-in: the popped byte appears only in the cycle after rd_uart
    always @(posedge clk) r_data <= rd_uart ? rx_next : 8'($urandom);

    function automatic logic f_irq(input logic re, input logic tf);
        return (m_ie[0] & ~re) | (m_ie[1] & ~tf) | (m_ie[2] & (m_ovf | m_udf));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a response or a TX push
    always @(negedge clk) begin
        resp_t e;
        tx_t   t;
        if (rd_uart === 1'b1) rd_seen++;
        if (apb.pready === 1'b1) begin
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected at cyc %0d prdata=%0h", cyc, apb.prdata);
            end else begin
                e = rq.pop_front();
                checks++;
                if (apb.prdata !== e.prdata || apb.pslverr !== e.err || cyc != e.due) begin
                    errors++;
                    $display("FAIL resp got prdata=%0h err=%0b cyc=%0d want prdata=%0h err=%0b cyc=%0d",
                             apb.prdata, apb.pslverr, cyc, e.prdata, e.err, e.due);
                end
            end
        end else if (reset_n && apb.pslverr !== 1'b0) begin
            errors++;
            $display("FAIL pslverr_outside_resp got %0b want 0 at cyc %0d", apb.pslverr, cyc);
        end
        if (wr_uart === 1'b1) begin
            if (txq.size() == 0) begin
                errors++;
                $display("FAIL wr_uart_unexpected at cyc %0d w_data=%0h", cyc, w_data);
            end else begin
                t = txq.pop_front();
                checks++;
                if (w_data !== t.dat || cyc != t.due) begin
                    errors++;
                    $display("FAIL tx_push got w_data=%0h cyc=%0d want w_data=%0h cyc=%0d",
                             w_data, cyc, t.dat, t.due);
                end
            end
        end
    end

    task automatic model_reset();
        m_div = 8'd162; m_ie = 3'b000; m_ovf = 1'b0; m_udf = 1'b0; m_prdata = 8'h00;
    endtask

    task automatic apb_xfer(input logic wr, input logic [1:0] a, input logic [7:0] wd,
                            input logic re, input logic tf);
        resp_t e;
        int    lat;
        bit    done;
        @(negedge clk);
        rx_empty = re; tx_full = tf;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
        apb.paddr = {a, 2'b00}; apb.pwdata = wd;
        @(negedge clk);
        apb.penable = 1'b1;
        lat = 1; e.err = 1'b0;
        case (a)
            ADDR_DATA: begin
                if (wr) begin
                    if (tf) begin e.err = 1'b1; m_ovf = 1'b1; end
                    else    txq.push_back('{wd, cyc + 1});
                end else if (re) begin
                    e.err = 1'b1; m_udf = 1'b1; m_prdata = 8'h00;
                end else begin
                    lat = 3; m_prdata = rx_next; rd_exp++;
                end
            end
            ADDR_STAT: begin
                if (wr) begin
                    if (wd[2]) m_ovf = 1'b0;
                    if (wd[3]) m_udf = 1'b0;
                end else m_prdata = {4'b0000, m_udf, m_ovf, tf, re};
            end
            ADDR_DIV: if (wr) m_div = wd; else m_prdata = m_div;
            default:  if (wr) m_ie = wd[2:0]; else m_prdata = {5'b00000, m_ie};
        endcase
        e.prdata = m_prdata; e.due = cyc + lat;
        rq.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (apb.pready === 1'b1) done = 1'b1;
        end
        apb.psel = 1'b0; apb.penable = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL pready_timeout addr=%0d wr=%0b", a, wr);
        end
        // Quiet window: irq and divisor reflect the model once inputs have settled
        repeat (2) @(negedge clk);
        chk("irq", irq, f_irq(re, tf));
        chk("div", timer_final_value, m_div);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] a;
        logic       wr, re, tf;
        logic [7:0] wd;
        bit         done;

        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = 4'h0; apb.pwdata = 8'h00;
        rx_empty = 1'b1; tx_full = 1'b0; rx_next = 8'h00;
        model_reset();

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pready",  apb.pready, 0);
        chk("rst_pslverr", apb.pslverr, 0);
        chk("rst_prdata",  apb.prdata, 0);
        chk("rst_wr_uart", wr_uart, 0);
        chk("rst_rd_uart", rd_uart, 0);
        chk("rst_w_data",  w_data, 0);
        chk("rst_paddr",   uart_paddr, 0);
        chk("rst_div",     timer_final_value, 8'd162);
        chk("rst_irq",     irq, 0);
        reset_n = 1'b1;

        // Directed walk through the main register behaviours
        apb_xfer(1'b0, ADDR_DIV,  8'h00, 1'b1, 1'b0);   // read 0xA2
        chk("paddr_div", uart_paddr, ADDR_DIV);
        apb_xfer(1'b1, ADDR_DATA, 8'h5A, 1'b1, 1'b0);   // TX push
        apb_xfer(1'b1, ADDR_DATA, 8'h33, 1'b1, 1'b1);   // overflow
        apb_xfer(1'b0, ADDR_STAT, 8'h00, 1'b1, 1'b0);   // 0x05
        apb_xfer(1'b1, ADDR_STAT, 8'h04, 1'b1, 1'b0);   // clear tx_ovf
        apb_xfer(1'b0, ADDR_STAT, 8'h00, 1'b1, 1'b0);   // 0x01
        rx_next = 8'hC3;
        apb_xfer(1'b0, ADDR_DATA, 8'h00, 1'b0, 1'b0);   // pop 0xC3
        apb_xfer(1'b0, ADDR_DATA, 8'h00, 1'b1, 1'b0);   // underflow
        apb_xfer(1'b1, ADDR_IE,   8'h04, 1'b1, 1'b0);   // err_ie -> irq 1
        chk("irq_err_on", irq, 1);
        apb_xfer(1'b1, ADDR_STAT, 8'h08, 1'b1, 1'b0);   // clear rx_udf -> irq 0
        chk("irq_err_off", irq, 0);
        apb_xfer(1'b1, ADDR_DIV,  8'h00, 1'b1, 1'b0);   // divisor 0 kept as written
        apb_xfer(1'b0, ADDR_DIV,  8'h00, 1'b1, 1'b0);

        // Randomized traffic
        repeat (300) begin
            a  = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            wd = 8'($urandom);
            re = 1'($urandom_range(0, 1));
            tf = 1'($urandom_range(0, 1));
            rx_next = 8'($urandom);
            apb_xfer(wr, a, wd, re, tf);
        end

        // Reset while the pop strobe is out: byte is lost, everything back to reset values
        @(negedge clk);
        rx_empty = 1'b0; tx_full = 1'b0; rx_next = 8'h77;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 4'h0;
        @(negedge clk);
        apb.penable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 6 && !done; i++) begin
            @(negedge clk);
            if (rd_uart === 1'b1) done = 1'b1;
        end
        chk("pop_started", done, 1);
        if (done) rd_exp++;
        #1 reset_n = 1'b0;
        #1 apb.psel = 1'b0; apb.penable = 1'b0;
        chk("mid_rst_rd_uart", rd_uart, 0);
        chk("mid_rst_pready",  apb.pready, 0);
        chk("mid_rst_prdata",  apb.prdata, 0);
        chk("mid_rst_paddr",   uart_paddr, 0);
        chk("mid_rst_div",     timer_final_value, 8'd162);
        chk("mid_rst_irq",     irq, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        apb_xfer(1'b0, ADDR_DIV, 8'h00, 1'b1, 1'b0);
        rx_next = 8'h3C;
        apb_xfer(1'b0, ADDR_DATA, 8'h00, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("rd_uart_count", rd_seen, rd_exp);
        chk("resp_queue_empty", rq.size(), 0);
        chk("tx_queue_empty", txq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
